mips_multicycle_core: RTL and testbench

- Multicycle MIPS-subset execution core: control decode, ALU control, and datapath (32x32 register file, ALU, 128-word data memory) behind a per-instruction phase sequencer.
- An external driver presents one instruction word and pulses newinstr.
- The core then walks ID, EX, MEM and WB, and signals done.
- Debug read ports expose the register file and memory to the bench.

---
 rtl/mips_multicycle_core.sv | 193 +++++++++++++++++++
 tb/tb_mips_multicycle_core.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/mips_multicycle_core.sv
// Multicycle MIPS-subset core: one instruction walks ID/EX/MEM/WB after a
// newinstr strobe, with debug read ports into the register file and data memory.
module mips_multicycle_core #(
    parameter int MEM_WORDS = 128,
    parameter int NREGS     = 32
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [31:0] instrword,
    input  logic        newinstr,
    input  logic [4:0]  dbg_reg_addr,
    output logic [31:0] dbg_reg_data,
    input  logic [6:0]  dbg_mem_addr,
    output logic [31:0] dbg_mem_data,
    output logic [31:0] alu_result,
    output logic        zero,
    output logic [2:0]  state,
    output logic        done
);
    typedef enum logic [2:0] {
        S_IDLE = 3'b000, S_ID = 3'b001, S_EX = 3'b010, S_MEM = 3'b011, S_WB = 3'b100
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] ir_q, ir_d;
    logic        reg_dst_q, reg_dst_d, alu_src_q, alu_src_d, mem_to_reg_q, mem_to_reg_d;
    logic        reg_write_q, reg_write_d, mem_write_q, mem_write_d;
    logic [3:0]  alu_ctrl_q, alu_ctrl_d;
    logic [31:0] alu_result_q, alu_result_d, mdr_q, mdr_d;
    logic        zero_q, zero_d, done_q, done_d;
    logic [31:0] regs_q [NREGS];
    logic [31:0] mem_q [MEM_WORDS];

    logic [5:0]  op, funct;
    logic [4:0]  rs, rt, rd, dest;
    logic [31:0] imm_sext, op_a, op_b, alu_out;
    logic [1:0]  alu_op;
    logic        rf_we, mem_we;
    logic [31:0] rf_wdata;

    assign op       = ir_q[31:26];
    assign rs       = ir_q[25:21];
    assign rt       = ir_q[20:16];
    assign rd       = ir_q[15:11];
    assign funct    = ir_q[5:0];
    assign imm_sext = {{16{ir_q[15]}}, ir_q[15:0]};
    assign op_a     = regs_q[rs];
    assign op_b     = alu_src_q ? imm_sext : regs_q[rt];
    assign dest     = reg_dst_q ? rd : rt;
    assign rf_wdata = mem_to_reg_q ? mdr_q : alu_result_q;

    always_comb begin
        alu_out = '0;
        case (alu_ctrl_q)
            4'b0010: alu_out = op_a + op_b;
            4'b0110: alu_out = op_a - op_b;
            4'b0000: alu_out = op_a & op_b;
            4'b0001: alu_out = op_a | op_b;
            4'b1100: alu_out = ~(op_a | op_b);
            4'b0111: alu_out = ($signed(op_a) < $signed(op_b)) ? 32'd1 : 32'd0;
            default: alu_out = '0;
        endcase
    end

    always_comb begin
        state_d      = state_q;
        ir_d         = ir_q;
        reg_dst_d    = reg_dst_q;
        alu_src_d    = alu_src_q;
        mem_to_reg_d = mem_to_reg_q;
        reg_write_d  = reg_write_q;
        mem_write_d  = mem_write_q;
        alu_ctrl_d   = alu_ctrl_q;
        alu_result_d = alu_result_q;
        zero_d       = zero_q;
        mdr_d        = mdr_q;
        done_d       = 1'b0;
        rf_we        = 1'b0;
        mem_we       = 1'b0;
        alu_op       = 2'b00;

        case (state_q)
            S_ID: begin
                state_d      = S_EX;
                reg_dst_d    = 1'b0;
                alu_src_d    = 1'b0;
                mem_to_reg_d = 1'b0;
                reg_write_d  = 1'b0;
                mem_write_d  = 1'b0;
                case (op)
                    6'h00: begin reg_dst_d = 1'b1; reg_write_d = 1'b1; alu_op = 2'b10; end
                    6'h23: begin alu_src_d = 1'b1; mem_to_reg_d = 1'b1; reg_write_d = 1'b1; end
                    6'h2B: begin alu_src_d = 1'b1; mem_write_d = 1'b1; end
                    6'h08: begin alu_src_d = 1'b1; reg_write_d = 1'b1; end
                    6'h04: alu_op = 2'b01;
                    default: ;
                endcase
                case (alu_op)
                    2'b01: alu_ctrl_d = 4'b0110;
                    2'b10: begin
                        case (funct)
                            6'h20: alu_ctrl_d = 4'b0010;
                            6'h22: alu_ctrl_d = 4'b0110;
                            6'h24: alu_ctrl_d = 4'b0000;
                            6'h25: alu_ctrl_d = 4'b0001;
                            6'h27: alu_ctrl_d = 4'b1100;
                            6'h2A: alu_ctrl_d = 4'b0111;
                            default: alu_ctrl_d = 4'b1111;
                        endcase
                    end
                    default: alu_ctrl_d = 4'b0010;
                endcase
                // An unsupported funct must not clobber its destination
                if (alu_ctrl_d == 4'b1111) reg_write_d = 1'b0;
            end
            S_EX: begin
                state_d      = S_MEM;
                alu_result_d = alu_out;
                zero_d       = (alu_out == 32'd0);
            end
            S_MEM: begin
                state_d = S_WB;
                mdr_d   = mem_q[alu_result_q[8:2]];
                mem_we  = mem_write_q;
            end
            S_WB: begin
                state_d = S_IDLE;
                rf_we   = reg_write_q && (dest != 5'd0);
                done_d  = 1'b1;
            end
            default: state_d = S_IDLE;
        endcase

        // A new strobe aborts whatever phase work would have happened at this edge
        if (newinstr) begin
            state_d      = S_ID;
            ir_d         = instrword;
            reg_dst_d    = reg_dst_q;
            alu_src_d    = alu_src_q;
            mem_to_reg_d = mem_to_reg_q;
            reg_write_d  = reg_write_q;
            mem_write_d  = mem_write_q;
            alu_ctrl_d   = alu_ctrl_q;
            alu_result_d = alu_result_q;
            zero_d       = zero_q;
            mdr_d        = mdr_q;
            done_d       = 1'b0;
            rf_we        = 1'b0;
            mem_we       = 1'b0;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q      <= S_IDLE;
            ir_q         <= '0;
            reg_dst_q    <= 1'b0;
            alu_src_q    <= 1'b0;
            mem_to_reg_q <= 1'b0;
            reg_write_q  <= 1'b0;
            mem_write_q  <= 1'b0;
            alu_ctrl_q   <= 4'b0010;
            alu_result_q <= '0;
            zero_q       <= 1'b1;
            mdr_q        <= '0;
            done_q       <= 1'b0;
            for (int i = 0; i < NREGS; i++) regs_q[i] <= '0;
            for (int i = 0; i < MEM_WORDS; i++) mem_q[i] <= '0;
        end else begin
            state_q      <= state_d;
            ir_q         <= ir_d;
            reg_dst_q    <= reg_dst_d;
            alu_src_q    <= alu_src_d;
            mem_to_reg_q <= mem_to_reg_d;
            reg_write_q  <= reg_write_d;
            mem_write_q  <= mem_write_d;
            alu_ctrl_q   <= alu_ctrl_d;
            alu_result_q <= alu_result_d;
            zero_q       <= zero_d;
            mdr_q        <= mdr_d;
            done_q       <= done_d;
            if (rf_we) regs_q[dest] <= rf_wdata;
            if (mem_we) mem_q[alu_result_q[8:2]] <= regs_q[rt];
        end
    end

    assign dbg_reg_data = regs_q[dbg_reg_addr];
    assign dbg_mem_data = mem_q[dbg_mem_addr];
    assign alu_result   = alu_result_q;
    assign zero         = zero_q;
    assign state        = state_q;
    assign done         = done_q;
endmodule

// File: tb/tb_mips_multicycle_core.sv
// Bench for mips_multicycle_core: directed table, abort/reset corner cases,
// then random instructions against an architectural reference model.
module tb_mips_multicycle_core;
    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic [31:0] instrword = '0;
    logic        newinstr = 1'b0;
    logic [4:0]  dbg_reg_addr = '0;
    logic [31:0] dbg_reg_data;
    logic [6:0]  dbg_mem_addr = '0;
    logic [31:0] dbg_mem_data;
    logic [31:0] alu_result;
    logic        zero;
    logic [2:0]  state;
    logic        done;

    mips_multicycle_core dut (
        .clock(clock), .reset(reset), .instrword(instrword), .newinstr(newinstr),
        .dbg_reg_addr(dbg_reg_addr), .dbg_reg_data(dbg_reg_data),
        .dbg_mem_addr(dbg_mem_addr), .dbg_mem_data(dbg_mem_data),
        .alu_result(alu_result), .zero(zero), .state(state), .done(done)
    );

    always #5 clock = ~clock;

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct {
        logic [31:0] instr;
        logic [4:0]  reg_idx;
        logic [31:0] reg_exp;
        logic [6:0]  mem_idx;
        logic [31:0] mem_exp;
        logic [31:0] alu_exp;
    } vec_t;
    vec_t vecs[16];

    logic [31:0] m_reg [32];
    logic [31:0] m_mem [128];
    logic [31:0] m_alu;
    logic        m_zero;
    logic [6:0]  m_addr;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic rd_reg(input int idx, output logic [31:0] v);
        dbg_reg_addr = 5'(idx);
        #1 v = dbg_reg_data;
    endtask

    task automatic rd_mem(input int idx, output logic [31:0] v);
        dbg_mem_addr = 7'(idx);
        #1 v = dbg_mem_data;
    endtask

    task automatic do_reset();
        @(negedge clock);
        reset = 1'b1; newinstr = 1'b0;
        @(posedge clock); #1;
        @(posedge clock); #1;
        reset = 1'b0;
    endtask

    task automatic strobe(input logic [31:0] ins);
        @(negedge clock);
        instrword = ins; newinstr = 1'b1;
        @(posedge clock); #1;
        newinstr = 1'b0;
    endtask

    // Returns the number of edges after the strobe edge until done is seen, -1 on timeout
    task automatic wait_done(output int lat);
        lat = -1;
        for (int k = 1; k <= 12; k++) begin
            @(posedge clock); #1;
            if (done) begin lat = k; break; end
        end
    endtask

    // Architectural effect of one instruction, straight from the ISA rules
    function automatic void model_exec(input logic [31:0] ins);
        logic [31:0] a, b, imm, res, wdata;
        logic [4:0]  dst;
        logic        wr;
        a = m_reg[ins[25:21]]; b = m_reg[ins[20:16]];
        imm = {{16{ins[15]}}, ins[15:0]};
        res = 0; wdata = 0; dst = ins[20:16]; wr = 1'b0;
        case (ins[31:26])
            6'h00: begin
                dst = ins[15:11]; wr = 1'b1;
                case (ins[5:0])
                    6'h20: res = a + b;
                    6'h22: res = a - b;
                    6'h24: res = a & b;
                    6'h25: res = a | b;
                    6'h27: res = ~(a | b);
                    6'h2A: res = ($signed(a) < $signed(b)) ? 1 : 0;
                    default: begin res = 0; wr = 1'b0; end
                endcase
                wdata = res;
            end
            6'h23: begin res = a + imm; m_addr = res[8:2]; wdata = m_mem[m_addr]; wr = 1'b1; end
            6'h2B: begin res = a + imm; m_addr = res[8:2]; m_mem[m_addr] = b; end
            6'h08: begin res = a + imm; wdata = res; wr = 1'b1; end
            6'h04: res = a - b;
            default: res = a + b;
        endcase
        m_alu = res;
        m_zero = (res == 0);
        if (wr && dst != 0) m_reg[dst] = wdata;
    endfunction

    initial begin
        logic [31:0] v;
        int lat;
        logic [5:0] fn_list [7];
        vecs[0]  = '{32'h20010005, 5'd1,  32'h5,        7'd0, 32'h0, 32'h5};
        vecs[1]  = '{32'h2002FFFD, 5'd2,  32'hFFFFFFFD, 7'd0, 32'h0, 32'hFFFFFFFD};
        vecs[2]  = '{32'h00221820, 5'd3,  32'h2,        7'd0, 32'h0, 32'h2};
        vecs[3]  = '{32'h00412022, 5'd4,  32'hFFFFFFF8, 7'd0, 32'h0, 32'hFFFFFFF8};
        vecs[4]  = '{32'h0041282A, 5'd5,  32'h1,        7'd0, 32'h0, 32'h1};
        vecs[5]  = '{32'h00223825, 5'd7,  32'hFFFFFFFD, 7'd0, 32'h0, 32'hFFFFFFFD};
        vecs[6]  = '{32'h00224024, 5'd8,  32'h5,        7'd0, 32'h0, 32'h5};
        vecs[7]  = '{32'h00224827, 5'd9,  32'h2,        7'd0, 32'h0, 32'h2};
        vecs[8]  = '{32'hAC010008, 5'd1,  32'h5,        7'd2, 32'h5, 32'h8};
        vecs[9]  = '{32'h8C060008, 5'd6,  32'h5,        7'd2, 32'h5, 32'h8};
        vecs[10] = '{32'hAC010204, 5'd1,  32'h5,        7'd1, 32'h5, 32'h204};
        vecs[11] = '{32'h20000007, 5'd0,  32'h0,        7'd1, 32'h5, 32'h7};
        vecs[12] = '{32'h10210000, 5'd1,  32'h5,        7'd2, 32'h5, 32'h0};
        vecs[13] = '{32'hFC260000, 5'd6,  32'h5,        7'd2, 32'h5, 32'hA};
        vecs[14] = '{32'h00225021, 5'd10, 32'h0,        7'd2, 32'h5, 32'h0};
        vecs[15] = '{32'h0022582A, 5'd11, 32'h0,        7'd1, 32'h5, 32'h0};
        fn_list = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h27, 6'h2A, 6'h21};

        do_reset();
        begin
            int bad_r, bad_m;
            bad_r = 0; bad_m = 0;
            for (int i = 0; i < 32; i++) begin rd_reg(i, v); if (v !== 0) bad_r++; end
            for (int i = 0; i < 128; i++) begin rd_mem(i, v); if (v !== 0) bad_m++; end
            chk("reset_regs_nonzero", 32'(bad_r), 32'd0);
            chk("reset_mem_nonzero", 32'(bad_m), 32'd0);
        end
        chk("reset_state", 32'(state), 32'd0);
        chk("reset_done", 32'(done), 32'd0);
        chk("reset_alu", alu_result, 32'd0);
        chk("reset_zero", 32'(zero), 32'd1);

        for (int i = 0; i < 16; i++) begin
            strobe(vecs[i].instr);
            wait_done(lat);
            chk($sformatf("v%0d_latency", i), 32'(lat), 32'd4);
            chk($sformatf("v%0d_alu", i), alu_result, vecs[i].alu_exp);
            chk($sformatf("v%0d_zero", i), 32'(zero), 32'(vecs[i].alu_exp == 0));
            chk($sformatf("v%0d_state", i), 32'(state), 32'd0);
            rd_reg(vecs[i].reg_idx, v);
            chk($sformatf("v%0d_reg%0d", i, vecs[i].reg_idx), v, vecs[i].reg_exp);
            rd_mem(vecs[i].mem_idx, v);
            chk($sformatf("v%0d_mem%0d", i, vecs[i].mem_idx), v, vecs[i].mem_exp);
            @(posedge clock); #1;
            chk($sformatf("v%0d_done_width", i), 32'(done), 32'd0);
        end

        // sw $2,12($0) aborted in MEM by addi $12,$0,9
        strobe(32'hAC02000C);
        @(posedge clock); #1;
        @(posedge clock); #1;
        chk("abort_in_mem_state", 32'(state), 32'd3);
        strobe(32'h200C0009);
        chk("abort_restart_state", 32'(state), 32'd1);
        wait_done(lat);
        chk("abort_latency", 32'(lat), 32'd4);
        rd_mem(3, v);
        chk("abort_mem3", v, 32'd0);
        rd_reg(12, v);
        chk("abort_reg12", v, 32'd9);

        // add $13,$1,$2 hit by reset during EX
        strobe(32'h00226820);
        @(posedge clock); #1;
        chk("rst_in_ex_state", 32'(state), 32'd2);
        @(negedge clock); reset = 1'b1;
        @(posedge clock); #1; reset = 1'b0;
        chk("rst_state", 32'(state), 32'd0);
        rd_reg(13, v);
        chk("rst_reg13", v, 32'd0);
        rd_reg(1, v);
        chk("rst_reg1", v, 32'd0);
        chk("rst_zero", 32'(zero), 32'd1);
        for (int k = 0; k < 4; k++) begin @(posedge clock); #1; end
        chk("rst_no_done", 32'(done), 32'd0);

        for (int i = 0; i < 32; i++) m_reg[i] = 0;
        for (int i = 0; i < 128; i++) m_mem[i] = 0;
        m_addr = 0;
        for (int t = 0; t < 200; t++) begin
            logic [31:0] ins;
            logic [4:0] rs, rt, rd;
            logic [15:0] imm;
            int kind;
            rs = 5'($urandom_range(0, 7)); rt = 5'($urandom_range(0, 7));
            rd = 5'($urandom_range(0, 7));
            imm = ($urandom_range(0, 3) == 0) ? 16'($urandom) : 16'($urandom_range(0, 255));
            kind = $urandom_range(0, 6);
            case (kind)
                0, 6: ins = {6'h00, rs, rt, rd, 5'd0, fn_list[$urandom_range(0, 6)]};
                1: ins = {6'h08, rs, rt, imm};
                2: ins = {6'h23, rs, rt, imm};
                3: ins = {6'h2B, rs, rt, imm};
                4: ins = {6'h04, rs, rt, imm};
                default: ins = {6'h0F, rs, rt, imm};
            endcase
            model_exec(ins);
            strobe(ins);
            wait_done(lat);
            chk($sformatf("r%0d_latency", t), 32'(lat), 32'd4);
            chk($sformatf("r%0d_alu ins=%h", t, ins), alu_result, m_alu);
            chk($sformatf("r%0d_zero", t), 32'(zero), 32'(m_zero));
            for (int r = 0; r < 8; r++) begin
                rd_reg(r, v);
                chk($sformatf("r%0d_reg%0d ins=%h", t, r, ins), v, m_reg[r]);
            end
            rd_mem(int'(m_addr), v);
            chk($sformatf("r%0d_mem%0d", t, m_addr), v, m_mem[m_addr]);
        end
        begin
            int bad_m;
            bad_m = 0;
            for (int i = 0; i < 128; i++) begin rd_mem(i, v); if (v !== m_mem[i]) bad_m++; end
            chk("final_mem_words_wrong", 32'(bad_m), 32'd0);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
